// File: rtl/imem_loader.sv
// Receives a framed byte stream (sync, length, data, XOR checksum), writes the
// little-endian words into instruction RAM and holds the core until the image is verified.
module imem_loader #(
    parameter int         ADDR_WIDTH     = 12,
    parameter int         DEPTH_WORDS    = 128,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int          CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             len_reg, len_next;
    logic [15:0]             word_idx_reg, word_idx_next;
    logic [1:0]              byte_idx_reg, byte_idx_next;
    logic [31:0]             word_reg, word_next;
    logic [7:0]              csum_reg, csum_next;
    logic [CNT_W-1:0]        idle_cnt_reg, idle_cnt_next;
    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic [15:0]             len_rx;
    logic                    in_frame;
    logic [31:0]             word_assembled;

    // Incoming byte lands in lane byte_idx; other lanes keep what was assembled so far.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_assembled[8*gi +: 8] =
                (byte_idx_reg == 2'(gi)) ? rx_data : word_reg[8*gi +: 8];
        end
    endgenerate

    assign len_rx   = {rx_data, len_reg[7:0]};
    assign in_frame = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                      (state_reg == ST_DATA)   || (state_reg == ST_CSUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            csum_reg     <= '0;
            idle_cnt_reg <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            word_idx_reg <= word_idx_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            csum_reg     <= csum_next;
            idle_cnt_reg <= idle_cnt_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_idx_next = word_idx_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        csum_next     = csum_reg;
        idle_cnt_next = idle_cnt_reg;
        we_next       = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;

        if (in_frame) begin
            idle_cnt_next = rx_valid ? '0 : idle_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next    = ST_LEN_LO;
                    idle_cnt_next = '0;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_next[7:0] = rx_data;
                    state_next    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_next[15:8] = rx_data;
                    word_idx_next  = '0;
                    byte_idx_next  = '0;
                    csum_next      = '0;
                    if (len_rx > DEPTH_W) begin
                        state_next = ST_ERROR;
                    end else if (len_rx == 16'd0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    word_next     = word_assembled;
                    csum_next     = csum_reg ^ rx_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        we_next       = 1'b1;
                        waddr_next    = ADDR_WIDTH'({word_idx_reg, 2'b00});
                        wdata_next    = word_assembled;
                        word_idx_next = word_idx_reg + 16'd1;
                        if (word_idx_reg == len_reg - 16'd1) begin
                            state_next = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    state_next = (rx_data == csum_reg) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A stalled sender aborts the frame; any byte this cycle counts as activity.
        if (in_frame && !rx_valid && idle_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_next = ST_ERROR;
        end
    end

    assign we        = we_reg;
    assign waddr     = waddr_reg;
    assign wdata     = wdata_reg;
    assign busy      = in_frame;
    assign done      = (state_reg == ST_DONE);
    assign error     = (state_reg == ST_ERROR);
    assign core_hold = (state_reg != ST_DONE);

endmodule
